candy_avb_onchip_mem_arbiter: RTL and testbench
===============================================

# candy_avb_onchip_mem_arbiter

Two-master burst arbiter sharing the single-port 2048x32 on-chip RAM between the Nios II data master (m0) and the AVB audio DMA (m1). It accepts Avalon-MM burst read and write commands, grants the RAM with round-robin fairness, and holds the grant for a whole burst. For reads it generates the incrementing burst addresses itself and returns data to the owning master with `readdatavalid`. It drives the RAM's address, byteenable, chipselect, write, writedata and clken, and takes its readdata (one-cycle read latency).

## Interface
- ADDR_W, 11, word address width (2048 words)
- DATA_W, 32, data width; byteenable width = DATA_W/8
- BURST_W, 5, burstcount width (max burst 16)

- clk  in  1  single clock; all logic rising-edge
- reset  in  1  asynchronous, active-high reset
- mN_address  in  ADDR_W  start word address, N = 0,1
- mN_burstcount  in  BURST_W  beats in burst; 0 is treated as 1
- mN_byteenable  in  DATA_W/8  byte lanes
- mN_read / mN_write  in  1  command strobes; write has priority if both are high
- mN_writedata  in  DATA_W  write data
- mN_waitrequest  out  1  command or beat not accepted this cycle
- mN_readdata  out  DATA_W  read data
- mN_readdatavalid  out  1  mN_readdata is valid
- mem_address  out  ADDR_W  RAM address
- mem_byteenable  out  DATA_W/8  RAM byte enables (all ones for reads)
- mem_chipselect / mem_write  out  1  RAM access strobes
- mem_writedata  out  DATA_W  RAM write data
- mem_clken  out  1  RAM clock enable; held 1
- mem_readdata  in  DATA_W  RAM data, valid one cycle after the address

## Operation
- FSM states: IDLE, RD_BURST, WR_BURST. Registers: owner, beat counter (BURST_W), address counter (ADDR_W), last_grant, rd_tag (valid + owner).
- **IDLE arbitration** (combinational from current requests):
  - Only one master requesting: that master wins.
  - Both requesting: the master ≠ last_grant wins.
  - Winner's waitrequest = 0; loser's waitrequest = 1. The first beat goes to the RAM in this same cycle. last_grant <= winner.
- **Read, burstcount B:**
  - Beat 0 is issued at the accept cycle.
  - B>1: go to RD_BURST, address counter = start+1, remaining = B-1.
  - RD_BURST issues one address per cycle (chipselect=1, write=0); both waitrequests are 1.
  - Leave to IDLE after the last address is issued.
- **Write, burstcount B:**
  - Beat 0 is written at the accept cycle.
  - B>1: go to WR_BURST.
  - In WR_BURST the owner's waitrequest = 0 each cycle; a beat is consumed only when the owner's write = 1.
  - Owner write = 0 stalls: no RAM access, counters hold. The non-owner's waitrequest = 1.
  - Leave to IDLE after the last beat.
- **Address** increments modulo 2^ADDR_W: 2047 wraps to 0.
- **Read return:**
  - rd_tag registers (read issued, owner) each cycle.
  - Next cycle: owner's readdatavalid = 1 and readdata = mem_readdata.
  - The other master's readdata = mem_readdata and readdatavalid = 0.
- **mem outputs when idle:** chipselect = 0, write = 0; address, byteenable and writedata are don't-care.
- **Reset** (async, any state, including mid-burst):
  - State = IDLE, counters = 0, last_grant = 1 (so m0 wins the first contention), rd_tag cleared.
  - An interrupted burst is abandoned; the master must reissue it.

## Timing
- Reset values:
  - mN_waitrequest = 1 while reset is high; after release, waitrequest follows the arbitration rules.
  - mN_readdatavalid = 0, mem_chipselect = 0, mem_write = 0.
  - mem_clken = 1, mem_address = 0.
- Read latency: command accepted at cycle t → readdatavalid at t+1 … t+B, one beat per cycle, no gaps.
- Read throughput: RAM is free for a new grant at cycle t+B. The last readdatavalid of one burst overlaps the new grant's first access without conflict.
- Write: back-to-back bursts are possible. Arbitration resumes the cycle after the last beat.
- Single-beat commands stay in IDLE; alternating contention gives one beat per cycle to each master in turn.
- Fairness: under continuous contention, grants alternate by burst, never by beat.

## Test plan
- Reset then m0 read, addr 0x010, B=1, RAM preloaded with word = addr → m0_waitrequest 0 at t; m0_readdatavalid at t+1 with 0x00000010; m1_readdatavalid stays 0.
- m1 write burst addr 0x7FE, B=4, data A0..A3, write deasserted for 2 cycles after beat 1 → RAM writes at 0x7FE, 0x7FF, 0x000, 0x001 (wrap); stall cycles show chipselect 0; m0 request during the burst sees waitrequest 1 until the burst ends.
- Both masters request single reads every cycle for 8 cycles after reset → grants m0,m1,m0,…; each master gets 4 readdatavalid pulses, each with correct data.
- m0 read B=16 from 0x100 while m1 holds a write request → 16 consecutive readdatavalid to m0 (0x100–0x10F); m1 accepted at t+16; m1 write lands the same cycle as m0's last readdatavalid.
- burstcount 0 read → treated as one beat: a single readdatavalid, FSM stays IDLE.
- Assert reset at beat 3 of an 8-beat m1 read → outputs at reset values immediately (async); no further readdatavalid; after release, a new m0 request is granted in its first cycle.

Source files
------------

// File: rtl/candy_avb_onchip_mem_arbiter.sv
// Two-master Avalon-MM burst arbiter for the single-port on-chip RAM.
// Round-robin by burst; reads are address-generated here and returned with readdatavalid.
module candy_avb_onchip_mem_arbiter #(
   parameter int ADDR_W  = 11,
   parameter int DATA_W  = 32,
   parameter int BURST_W = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_W-1:0]     m0_address,
   input  logic [BURST_W-1:0]    m0_burstcount,
   input  logic [DATA_W/8-1:0]   m0_byteenable,
   input  logic                  m0_read,
   input  logic                  m0_write,
   input  logic [DATA_W-1:0]     m0_writedata,
   output logic                  m0_waitrequest,
   output logic [DATA_W-1:0]     m0_readdata,
   output logic                  m0_readdatavalid,
   input  logic [ADDR_W-1:0]     m1_address,
   input  logic [BURST_W-1:0]    m1_burstcount,
   input  logic [DATA_W/8-1:0]   m1_byteenable,
   input  logic                  m1_read,
   input  logic                  m1_write,
   input  logic [DATA_W-1:0]     m1_writedata,
   output logic                  m1_waitrequest,
   output logic [DATA_W-1:0]     m1_readdata,
   output logic                  m1_readdatavalid,
   output logic [ADDR_W-1:0]     mem_address,
   output logic [DATA_W/8-1:0]   mem_byteenable,
   output logic                  mem_chipselect,
   output logic                  mem_write,
   output logic [DATA_W-1:0]     mem_writedata,
   output logic                  mem_clken,
   input  logic [DATA_W-1:0]     mem_readdata
);

   localparam int BE_W = DATA_W / 8;

   typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_t;

   state_t               r_state, w_state_nxt;
   logic                 r_owner, w_owner_nxt;
   logic                 r_last_grant, w_last_nxt;
   logic [ADDR_W-1:0]    r_addr, w_addr_nxt;
   logic [BURST_W-1:0]   r_beats, w_beats_nxt;
   logic                 r_rd_valid;
   logic                 r_rd_owner;
   logic                 w_acc_owner;

   logic                 w_req0, w_req1, w_winner;
   logic                 w_win_write;
   logic [ADDR_W-1:0]    w_win_addr;
   logic [BURST_W-1:0]   w_win_bc, w_bc_eff;
   logic [BE_W-1:0]      w_win_be, w_own_be;
   logic [DATA_W-1:0]    w_win_wdata, w_own_wdata;
   logic                 w_own_write;

   assign w_req0   = m0_read | m0_write;
   assign w_req1   = m1_read | m1_write;
   // Sole requester wins; on contention the master not granted last time wins.
   assign w_winner = (w_req0 && w_req1) ? ~r_last_grant : w_req1;

   assign w_win_write = w_winner ? m1_write      : m0_write;
   assign w_win_addr  = w_winner ? m1_address    : m0_address;
   assign w_win_bc    = w_winner ? m1_burstcount : m0_burstcount;
   assign w_win_be    = w_winner ? m1_byteenable : m0_byteenable;
   assign w_win_wdata = w_winner ? m1_writedata  : m0_writedata;
   assign w_bc_eff    = (w_win_bc == '0) ? BURST_W'(1) : w_win_bc;

   assign w_own_write = r_owner ? m1_write      : m0_write;
   assign w_own_be    = r_owner ? m1_byteenable : m0_byteenable;
   assign w_own_wdata = r_owner ? m1_writedata  : m0_writedata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_owner      <= 1'b0;
         r_last_grant <= 1'b1;
         r_addr       <= '0;
         r_beats      <= '0;
         r_rd_valid   <= 1'b0;
         r_rd_owner   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_owner      <= w_owner_nxt;
         r_last_grant <= w_last_nxt;
         r_addr       <= w_addr_nxt;
         r_beats      <= w_beats_nxt;
         r_rd_valid   <= mem_chipselect & ~mem_write;
         r_rd_owner   <= w_acc_owner;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_owner_nxt    = r_owner;
      w_last_nxt     = r_last_grant;
      w_addr_nxt     = r_addr;
      w_beats_nxt    = r_beats;
      w_acc_owner    = r_owner;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
      mem_address    = r_addr;
      mem_byteenable = '1;
      mem_chipselect = 1'b0;
      mem_write      = 1'b0;
      mem_writedata  = '0;
      // Combinational outputs are gated so they sit at reset values while reset is high.
      if (!reset) begin
         case (r_state)
            IDLE: begin
               if (w_req0 || w_req1) begin
                  m0_waitrequest = w_winner;
                  m1_waitrequest = ~w_winner;
                  mem_chipselect = 1'b1;
                  mem_write      = w_win_write;
                  mem_address    = w_win_addr;
                  mem_byteenable = w_win_write ? w_win_be : '1;
                  mem_writedata  = w_win_wdata;
                  w_acc_owner    = w_winner;
                  w_owner_nxt    = w_winner;
                  w_last_nxt     = w_winner;
                  if (w_bc_eff != BURST_W'(1)) begin
                     w_state_nxt = w_win_write ? WR_BURST : RD_BURST;
                     w_addr_nxt  = w_win_addr + 1'b1;
                     w_beats_nxt = w_bc_eff - 1'b1;
                  end
               end
            end
            RD_BURST: begin
               mem_chipselect = 1'b1;
               mem_address    = r_addr;
               w_addr_nxt     = r_addr + 1'b1;
               w_beats_nxt    = r_beats - 1'b1;
               if (r_beats == BURST_W'(1)) w_state_nxt = IDLE;
            end
            WR_BURST: begin
               m0_waitrequest = r_owner;
               m1_waitrequest = ~r_owner;
               if (w_own_write) begin
                  mem_chipselect = 1'b1;
                  mem_write      = 1'b1;
                  mem_address    = r_addr;
                  mem_byteenable = w_own_be;
                  mem_writedata  = w_own_wdata;
                  w_addr_nxt     = r_addr + 1'b1;
                  w_beats_nxt    = r_beats - 1'b1;
                  if (r_beats == BURST_W'(1)) w_state_nxt = IDLE;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   assign m0_readdata      = mem_readdata;
   assign m1_readdata      = mem_readdata;
   assign m0_readdatavalid = r_rd_valid & ~r_rd_owner;
   assign m1_readdatavalid = r_rd_valid &  r_rd_owner;
   assign mem_clken        = 1'b1;

endmodule

// File: tb/tb_candy_avb_onchip_mem_arbiter.sv
// Directed self-checking bench for candy_avb_onchip_mem_arbiter with a behavioural
// 2048x32 one-cycle-latency RAM preloaded with word = address.
module tb_candy_avb_onchip_mem_arbiter;

   logic        clk;
   logic        reset;
   logic [10:0] m0_address, m1_address;
   logic [4:0]  m0_burstcount, m1_burstcount;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [31:0] m0_writedata, m1_writedata;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic [10:0] mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect, mem_write, mem_clken;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata;

   logic [31:0] ram [0:2047];
   bit          ram_loaded;

   int n_tests = 0;
   int n_fail  = 0;
   int cnt0, cnt1;

   candy_avb_onchip_mem_arbiter #(
      .ADDR_W  (11),
      .DATA_W  (32),
      .BURST_W (5)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .m0_address       (m0_address),
      .m0_burstcount    (m0_burstcount),
      .m0_byteenable    (m0_byteenable),
      .m0_read          (m0_read),
      .m0_write         (m0_write),
      .m0_writedata     (m0_writedata),
      .m0_waitrequest   (m0_waitrequest),
      .m0_readdata      (m0_readdata),
      .m0_readdatavalid (m0_readdatavalid),
      .m1_address       (m1_address),
      .m1_burstcount    (m1_burstcount),
      .m1_byteenable    (m1_byteenable),
      .m1_read          (m1_read),
      .m1_write         (m1_write),
      .m1_writedata     (m1_writedata),
      .m1_waitrequest   (m1_waitrequest),
      .m1_readdata      (m1_readdata),
      .m1_readdatavalid (m1_readdatavalid),
      .mem_address      (mem_address),
      .mem_byteenable   (mem_byteenable),
      .mem_chipselect   (mem_chipselect),
      .mem_write        (mem_write),
      .mem_writedata    (mem_writedata),
      .mem_clken        (mem_clken),
      .mem_readdata     (mem_readdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!ram_loaded) begin
         for (int i = 0; i < 2048; i++) ram[i] <= 32'(i);
         mem_readdata <= '0;
         ram_loaded   <= 1'b1;
      end else if (mem_chipselect && mem_clken) begin
         if (mem_write) begin
            for (int b = 0; b < 4; b++)
               if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
         end else begin
            mem_readdata <= ram[mem_address];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
   endtask

   initial begin
      reset = 1;
      idle_inputs();
      m0_address = '0; m1_address = '0;
      m0_burstcount = 5'd1; m1_burstcount = 5'd1;
      m0_byteenable = 4'hF; m1_byteenable = 4'hF;
      m0_writedata = '0; m1_writedata = '0;
      repeat (2) step();

      // Reset values with a request pending
      m0_read = 1; m0_address = 11'h010; m0_burstcount = 5'd1;
      @(negedge clk);
      check("rst_m0_wait", 32'(m0_waitrequest), 32'd1);
      check("rst_m1_wait", 32'(m1_waitrequest), 32'd1);
      check("rst_cs", 32'(mem_chipselect), 32'd0);
      check("rst_wr", 32'(mem_write), 32'd0);
      check("rst_addr", 32'(mem_address), 32'd0);
      check("rst_clken", 32'(mem_clken), 32'd1);
      check("rst_rdv0", 32'(m0_readdatavalid), 32'd0);

      // Test 1: single read 0x010
      step(); reset = 0;
      @(negedge clk);
      check("t1_m0_wait", 32'(m0_waitrequest), 32'd0);
      check("t1_m1_wait", 32'(m1_waitrequest), 32'd1);
      check("t1_cs", 32'(mem_chipselect), 32'd1);
      check("t1_addr", 32'(mem_address), 32'h010);
      step(); m0_read = 0;
      @(negedge clk);
      check("t1_rdv0", 32'(m0_readdatavalid), 32'd1);
      check("t1_data", m0_readdata, 32'h10);
      check("t1_rdv1", 32'(m1_readdatavalid), 32'd0);

      // Test 2: m1 write burst with wrap and stall, m0 waits
      step();
      m1_write = 1; m1_address = 11'h7FE; m1_burstcount = 5'd4; m1_writedata = 32'hA0;
      @(negedge clk);
      check("t2_b0_wait", 32'(m1_waitrequest), 32'd0);
      check("t2_b0_wr", 32'(mem_write), 32'd1);
      check("t2_b0_addr", 32'(mem_address), 32'h7FE);
      step();
      m1_writedata = 32'hA1; m0_read = 1; m0_address = 11'h020; m0_burstcount = 5'd1;
      @(negedge clk);
      check("t2_b1_m1wait", 32'(m1_waitrequest), 32'd0);
      check("t2_b1_m0wait", 32'(m0_waitrequest), 32'd1);
      check("t2_b1_addr", 32'(mem_address), 32'h7FF);
      check("t2_b1_cs", 32'(mem_chipselect), 32'd1);
      for (int s = 0; s < 2; s++) begin
         step(); m1_write = 0;
         @(negedge clk);
         check("t2_stall_cs", 32'(mem_chipselect), 32'd0);
         check("t2_stall_m0wait", 32'(m0_waitrequest), 32'd1);
         check("t2_stall_m1wait", 32'(m1_waitrequest), 32'd0);
      end
      step(); m1_write = 1; m1_writedata = 32'hA2;
      @(negedge clk);
      check("t2_b2_addr", 32'(mem_address), 32'h000);
      check("t2_b2_cs", 32'(mem_chipselect), 32'd1);
      step(); m1_writedata = 32'hA3;
      @(negedge clk);
      check("t2_b3_addr", 32'(mem_address), 32'h001);
      check("t2_b3_m0wait", 32'(m0_waitrequest), 32'd1);
      step(); m1_write = 0;
      @(negedge clk);
      check("t2_m0_grant", 32'(m0_waitrequest), 32'd0);
      check("t2_m0_addr", 32'(mem_address), 32'h020);
      check("t2_ram7fe", ram[11'h7FE], 32'hA0);
      check("t2_ram7ff", ram[11'h7FF], 32'hA1);
      check("t2_ram000", ram[11'h000], 32'hA2);
      check("t2_ram001", ram[11'h001], 32'hA3);
      step(); m0_read = 0;
      @(negedge clk);
      check("t2_rdv0", 32'(m0_readdatavalid), 32'd1);
      check("t2_data", m0_readdata, 32'h20);

      // Test 3: alternating single-read contention after a reset
      step(); reset = 1;
      step(); reset = 0;
      cnt0 = 0; cnt1 = 0;
      for (int k = 0; k < 8; k++) begin
         m0_read = 1; m0_address = 11'(32'h40 + (k + 1) / 2); m0_burstcount = 5'd1;
         m1_read = 1; m1_address = 11'(32'h80 + k / 2);       m1_burstcount = 5'd1;
         @(negedge clk);
         check("t3_m0_wait", 32'(m0_waitrequest), 32'(k % 2));
         check("t3_m1_wait", 32'(m1_waitrequest), 32'(1 - k % 2));
         check("t3_addr", 32'(mem_address), (k % 2 == 0) ? 32'(32'h40 + k / 2) : 32'(32'h80 + k / 2));
         if (k > 0) begin
            if ((k - 1) % 2 == 0) begin
               check("t3_rdv0", 32'(m0_readdatavalid), 32'd1);
               check("t3_data0", m0_readdata, 32'(32'h40 + (k - 1) / 2));
            end else begin
               check("t3_rdv1", 32'(m1_readdatavalid), 32'd1);
               check("t3_data1", m1_readdata, 32'(32'h80 + (k - 1) / 2));
            end
         end
         if (m0_readdatavalid) cnt0++;
         if (m1_readdatavalid) cnt1++;
         step();
      end
      idle_inputs();
      @(negedge clk);
      check("t3_last_rdv1", 32'(m1_readdatavalid), 32'd1);
      check("t3_last_data", m1_readdata, 32'h83);
      if (m0_readdatavalid) cnt0++;
      if (m1_readdatavalid) cnt1++;
      check("t3_cnt0", 32'(cnt0), 32'd4);
      check("t3_cnt1", 32'(cnt1), 32'd4);

      // Test 4: 16-beat m0 read while m1 holds a write
      step();
      m0_read = 1; m0_address = 11'h100; m0_burstcount = 5'd16;
      m1_write = 1; m1_address = 11'h200; m1_burstcount = 5'd1; m1_writedata = 32'hCAFE0001;
      @(negedge clk);
      check("t4_m0_wait", 32'(m0_waitrequest), 32'd0);
      check("t4_m1_wait", 32'(m1_waitrequest), 32'd1);
      step(); m0_read = 0;
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         check("t4_rdv", 32'(m0_readdatavalid), 32'd1);
         check("t4_data", m0_readdata, 32'(32'h100 + i - 1));
         check("t4_addr", 32'(mem_address), 32'(32'h100 + i));
         check("t4_m1_wait", 32'(m1_waitrequest), 32'd1);
         step();
      end
      @(negedge clk);
      check("t4_last_rdv", 32'(m0_readdatavalid), 32'd1);
      check("t4_last_data", m0_readdata, 32'h10F);
      check("t4_m1_grant", 32'(m1_waitrequest), 32'd0);
      check("t4_m1_wr", 32'(mem_write), 32'd1);
      check("t4_m1_addr", 32'(mem_address), 32'h200);
      step(); m1_write = 0;
      @(negedge clk);
      check("t4_ram200", ram[11'h200], 32'hCAFE0001);
      check("t4_rdv_end", 32'(m0_readdatavalid), 32'd0);

      // Test 5: burstcount 0 read is a single beat
      step();
      m0_read = 1; m0_address = 11'h030; m0_burstcount = 5'd0;
      @(negedge clk);
      check("t5_wait", 32'(m0_waitrequest), 32'd0);
      step(); m0_read = 0;
      @(negedge clk);
      check("t5_rdv", 32'(m0_readdatavalid), 32'd1);
      check("t5_data", m0_readdata, 32'h30);
      check("t5_cs_idle", 32'(mem_chipselect), 32'd0);
      step();
      @(negedge clk);
      check("t5_rdv_once", 32'(m0_readdatavalid), 32'd0);

      // Test 6: async reset in the middle of an 8-beat m1 read
      step();
      m1_read = 1; m1_address = 11'h300; m1_burstcount = 5'd8;
      @(negedge clk);
      check("t6_m1_wait", 32'(m1_waitrequest), 32'd0);
      step(); m1_read = 0;
      @(negedge clk);
      check("t6_rdv1", 32'(m1_readdatavalid), 32'd1);
      check("t6_data", m1_readdata, 32'h300);
      step(); step();
      #2 reset = 1;
      #1;
      check("t6_async_cs", 32'(mem_chipselect), 32'd0);
      check("t6_async_addr", 32'(mem_address), 32'd0);
      check("t6_async_rdv1", 32'(m1_readdatavalid), 32'd0);
      check("t6_async_m0wait", 32'(m0_waitrequest), 32'd1);
      check("t6_async_m1wait", 32'(m1_waitrequest), 32'd1);
      @(negedge clk);
      check("t6_rst_rdv1", 32'(m1_readdatavalid), 32'd0);
      check("t6_rst_cs", 32'(mem_chipselect), 32'd0);
      step(); reset = 0;
      m0_read = 1; m0_address = 11'h050; m0_burstcount = 5'd1;
      @(negedge clk);
      check("t6_m0_grant", 32'(m0_waitrequest), 32'd0);
      check("t6_m0_addr", 32'(mem_address), 32'h050);
      step(); m0_read = 0;
      @(negedge clk);
      check("t6_rdv0", 32'(m0_readdatavalid), 32'd1);
      check("t6_data0", m0_readdata, 32'h50);
      check("t6_no_rdv1", 32'(m1_readdatavalid), 32'd0);
      check("t6_idle_cs", 32'(mem_chipselect), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
